// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the command-master state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_A,
        RD_D,
        RSP
    } state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one command in, one bus transaction out, one response back.
// Handshakes: a beat transfers on the rising aclk edge where valid && ready are both high.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output state_t            o_dbg_state
);

    localparam bit                TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam int                CNT_W     = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_timeout;
    logic [CNT_W-1:0]    r_tmo_cnt;

    logic                w_aw_done;
    logic                w_w_done;
    logic                w_in_bus;
    logic [CNT_W-1:0]    w_tmo_next;
    logic                w_tmo_hit;

    // A channel counts as done once its beat has gone, or if it goes on this edge.
    assign w_aw_done  = !r_awvalid || awready;
    assign w_w_done   = !r_wvalid  || wready;
    assign w_in_bus   = (r_state == WR) || (r_state == WR_B) ||
                        (r_state == RD_A) || (r_state == RD_D);
    assign w_tmo_next = r_tmo_cnt + CNT_W'(1);
    assign w_tmo_hit  = TMO_EN && w_in_bus && (w_tmo_next == TMO_LIMIT);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_tmo_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= cmd_write;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_tmo_cnt   <= '0;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_A;
                        end
                    end
                end
                WR: begin
                    if (r_awvalid && awready) r_awvalid <= 1'b0;
                    if (r_wvalid && wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid && r_bready) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_resp    <= bresp;
                        r_rsp_rdata   <= '0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RSP;
                    end
                end
                RD_A: begin
                    if (r_arvalid && arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid && r_rready) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_resp    <= rresp;
                        r_rsp_rdata   <= rdata;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Abort overrides any bus progress on the same edge; the slave is treated as hung.
            if (TMO_EN && w_in_bus) r_tmo_cnt <= w_tmo_next;
            if (w_tmo_hit) begin
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_resp    <= RESP_DECERR;
                r_rsp_rdata   <= '0;
                r_rsp_timeout <= 1'b1;
                r_state       <= RSP;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;
    assign awaddr      = r_addr;
    assign awprot      = 3'b000;
    assign awvalid     = r_awvalid;
    assign wdata       = r_wdata;
    assign wstrb       = 4'hF;
    assign wvalid      = r_wvalid;
    assign bready      = r_bready;
    assign araddr      = r_addr;
    assign arprot      = 3'b000;
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a small reactive AXI4-Lite register slave.
module tb_axi_lite_cmd_master;
    import axi_lite_pkg::*;

    localparam int ADDR_W = 3;
    localparam int TMO    = 16;

    logic              aclk      = 1'b0;
    logic              aresetn   = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [31:0]       cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready = 1'b0;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready  = 1'b0;
    logic [1:0]        bresp   = 2'b00;
    logic              bvalid  = 1'b0;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [31:0]       rdata   = '0;
    logic [1:0]        rresp   = 2'b00;
    logic              rvalid  = 1'b0;
    logic              rready;
    state_t            dbg_state;

    axi_lite_cmd_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- slave model ----------------
    int          aw_delay   = 0;
    int          w_delay    = 0;
    bit          ar_hang    = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    int          b_cnt      = 0;
    logic [31:0] mem [8];
    int          aw_wait, w_wait;
    bit          got_aw, got_w, b_pend, r_pend;
    logic [2:0]  s_addr;
    logic [31:0] s_data, r_data_q;

    // Handshakes are read at the edge (pre-update values), responses driven 1 time unit later.
    always begin
        @(posedge aclk);
        if (!aresetn) begin
            got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
            aw_wait = 0; w_wait = 0;
            for (int i = 0; i < 8; i++) mem[i] = '0;
            mem[7] = 32'hA5A5_0007;
        end else begin
            if (bvalid && bready) begin b_pend = 1'b0; b_cnt++; end
            if (rvalid && rready) r_pend = 1'b0;
            if (awvalid && awready) begin got_aw = 1'b1; s_addr = awaddr; aw_wait = 0; end
            else if (awvalid) aw_wait++;
            if (wvalid && wready) begin got_w = 1'b1; s_data = wdata; w_wait = 0; end
            else if (wvalid) w_wait++;
            if (got_aw && got_w) begin
                mem[s_addr] = s_data; got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b1;
            end
            if (arvalid && arready) begin r_pend = 1'b1; r_data_q = mem[araddr]; end
        end
        #1;
        awready = awvalid && (aw_wait >= aw_delay);
        wready  = wvalid && (w_wait >= w_delay);
        bvalid  = b_pend;
        bresp   = b_pend ? b_resp_cfg : 2'b00;
        arready = arvalid && !ar_hang;
        rvalid  = r_pend;
        rdata   = r_pend ? r_data_q : 32'h0;
        rresp   = r_pend ? r_resp_cfg : 2'b00;
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          accept_cyc = 0;
    logic [35:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
        check_eq("cmd_accept", 64'(cmd_ready), 64'(1));
        @(negedge aclk);
        accept_cyc = cyc;
        // Scramble the command inputs; the latched copy must not follow them.
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = 32'hDEAD_BEEF;
    endtask

    task automatic wait_rsp(input int exp_lat, input int hold);
        int n;
        logic [35:0] exp;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
        check_eq("rsp_seen", 64'(rsp_valid), 64'(1));
        check_eq("rsp_latency", 64'(cyc - accept_cyc + 1), 64'(exp_lat));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hF_FFFF_FFFF;
        check_eq("rsp_payload", 64'({rsp_write, rsp_timeout, rsp_resp, rsp_rdata}), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            check_eq("rsp_hold", 64'({rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}),
                     64'({1'b1, exp}));
            check_eq("cmd_ready_hold", 64'(cmd_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check_eq("rsp_drop", 64'(rsp_valid), 64'(0));
        check_eq("cmd_ready_back", 64'(cmd_ready), 64'(1));
    endtask

    // ---------------- directed tests ----------------
    int n;
    int b_before;

    initial begin
        repeat (3) @(negedge aclk);
        check_eq("rst_outputs", 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                                     rsp_valid, rsp_write, rsp_timeout, rsp_resp}), 64'(0));
        check_eq("rst_data", 64'({awaddr, wdata, rsp_rdata}), 64'(0));
        check_eq("rst_state", 64'(dbg_state), 64'(IDLE));

        // Release: cmd_ready rises one cycle later; rsp_ready in IDLE must do nothing.
        aresetn = 1'b1; rsp_ready = 1'b1;
        @(negedge aclk);
        check_eq("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));
        @(negedge aclk);
        check_eq("idle_rsp_ready", 64'({rsp_valid, dbg_state}), 64'({1'b0, IDLE}));
        rsp_ready = 1'b0;

        // 1: write 0x1 to addr 1, zero-wait slave.
        b_before = b_cnt;
        send_cmd(1'b1, 3'd1, 32'h0000_0001);
        exp_q.push_back({1'b1, 1'b0, RESP_OKAY, 32'h0});
        check_eq("t1_aw_w_together", 64'({awvalid, wvalid, bready, cmd_ready}), 64'(4'b1100));
        check_eq("t1_aw_data", 64'({awaddr, wdata, wstrb, awprot}), 64'({3'd1, 32'h1, 4'hF, 3'b000}));
        @(negedge aclk);
        check_eq("t1_wr_b", 64'({awvalid, wvalid, bready}), 64'(3'b001));
        wait_rsp(3, 0);
        check_eq("t1_b_count", 64'(b_cnt - b_before), 64'(1));

        // 2: write 0x1234 to addr 2, awready one cycle ahead of wready.
        aw_delay = 0; w_delay = 1;
        b_before = b_cnt;
        send_cmd(1'b1, 3'd2, 32'h0000_1234);
        exp_q.push_back({1'b1, 1'b0, RESP_OKAY, 32'h0});
        check_eq("t2_both_up", 64'({awvalid, wvalid}), 64'(2'b11));
        @(negedge aclk);
        check_eq("t2_aw_first", 64'({awvalid, wvalid, bready}), 64'(3'b010));
        check_eq("t2_wdata_stable", 64'(wdata), 64'(32'h0000_1234));
        @(negedge aclk);
        check_eq("t2_w_done", 64'({awvalid, wvalid, bready}), 64'(3'b001));
        wait_rsp(4, 0);
        check_eq("t2_b_count", 64'(b_cnt - b_before), 64'(1));
        w_delay = 0;

        // 3: read addr 2 back.
        send_cmd(1'b0, 3'd2, 32'h0);
        exp_q.push_back({1'b0, 1'b0, RESP_OKAY, 32'h0000_1234});
        check_eq("t3_ar", 64'({arvalid, araddr, arprot, rready, awvalid}), 64'({1'b1, 3'd2, 3'b000, 1'b0, 1'b0}));
        wait_rsp(3, 0);

        // 4: read addr 7 with SLVERR, passed through unmodified.
        r_resp_cfg = RESP_SLVERR;
        send_cmd(1'b0, 3'd7, 32'h0);
        exp_q.push_back({1'b0, 1'b0, RESP_SLVERR, 32'hA5A5_0007});
        wait_rsp(3, 0);
        r_resp_cfg = RESP_OKAY;

        // 5: slave never takes AR -> abort after 16 bus cycles; hold response 5 cycles.
        ar_hang = 1'b1;
        send_cmd(1'b0, 3'd3, 32'h0);
        exp_q.push_back({1'b0, 1'b1, 2'b11, 32'h0});
        n = 0;
        while (arvalid && n < 40) begin @(negedge aclk); n++; end
        check_eq("t5_arvalid_cycles", 64'(n), 64'(16));
        check_eq("t5_all_low", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'(0));
        wait_rsp(17, 5);
        ar_hang = 1'b0;

        // 6: reset while stuck in WR; no response for the aborted write.
        aw_delay = 1000;
        send_cmd(1'b1, 3'd5, 32'h0000_0055);
        check_eq("t6_in_wr", 64'({awvalid, dbg_state}), 64'({1'b1, WR}));
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        check_eq("t6_rst_outputs", 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready,
                                        rsp_valid, rsp_timeout, rsp_resp}), 64'(0));
        check_eq("t6_rst_data", 64'({awaddr, wdata, rsp_rdata, dbg_state}), 64'({3'd0, 32'h0, 32'h0, IDLE}));
        aresetn = 1'b1;
        aw_delay = 0;
        @(negedge aclk);
        check_eq("t6_cmd_ready", 64'({cmd_ready, rsp_valid}), 64'(2'b10));

        // 7: recovery after reset.
        send_cmd(1'b1, 3'd5, 32'hCAFE_0005);
        exp_q.push_back({1'b1, 1'b0, RESP_OKAY, 32'h0});
        wait_rsp(3, 0);
        send_cmd(1'b0, 3'd5, 32'h0);
        exp_q.push_back({1'b0, 1'b0, RESP_OKAY, 32'hCAFE_0005});
        wait_rsp(3, 0);

        check_eq("exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
